full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/fa_pkg.sv | 10 +
 rtl/fa_cell.sv | 13 +
 rtl/full_adder.sv | 54 +++++
 tb/tb_full_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants and the operand-width legality check for the full_adder slice.
package fa_pkg;

    localparam int FA_MAX_WIDTH = 32;

    function automatic bit fa_width_ok(input int width);
        return (width >= 1) && (width <= FA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; purely combinational, chained by full_adder into a ripple adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a one-cycle registered copy.
module full_adder
    import fa_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             valid_q
);

    if (!fa_width_ok(WIDTH)) begin : g_bad_width
        $error("full_adder: WIDTH must be in 1..FA_MAX_WIDTH");
    end

    // carry[i] feeds bit i; carry[WIDTH] is the overflow of the whole word.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

    // valid_q has no ready partner: once high it means sum_q/cout_q hold the
    // result sampled at the latest rising edge, and it stays high until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            cout_q  <= cout;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder at WIDTH=1 and WIDTH=4 with a queued scoreboard.
`timescale 1ns/100ps
module tb_full_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       a1, b1, cin1, sum1, cout1, sum_q1, cout_q1, valid_q1;
    logic [3:0] a4, b4, sum4, sum_q4;
    logic       cin4, cout4, cout_q4, valid_q4;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .valid_q(valid_q1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4), .valid_q(valid_q4)
    );

    // ---------------- scoreboard ----------------
    // sel: 0 dut1 {cout,sum}, 1 dut1 {valid_q,cout_q,sum_q},
    //      2 dut4 {cout,sum}, 3 dut4 {valid_q,cout_q,sum_q}
    logic [5:0] exp_q[$];
    logic [1:0] sel_q[$];
    string      tag_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    event       check_ev;

    task automatic expect_val(input string tag, input logic [1:0] sel, input logic [5:0] exp);
        exp_q.push_back(exp);
        sel_q.push_back(sel);
        tag_q.push_back(tag);
    endtask

    task automatic fire();
        -> check_ev;
        #2;
    endtask

    initial begin : monitor
        logic [5:0] e, act;
        logic [1:0] s;
        string      t;
        forever begin
            @(check_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                t = tag_q.pop_front();
                case (s)
                    2'd0:    act = {4'b0, cout1, sum1};
                    2'd1:    act = {3'b0, valid_q1, cout_q1, sum_q1};
                    2'd2:    act = {1'b0, cout4, sum4};
                    default: act = {valid_q4, cout_q4, sum_q4};
                endcase
                tests_run++;
                if (act !== e) begin
                    tests_failed++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", t, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] tbl1 [8];

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        {a1, b1, cin1} = 3'b000;
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;

        // Reset state and combinational path during reset
        @(negedge clk);
        expect_val("reset_w1", 2'd1, 6'h00);
        expect_val("reset_w4", 2'd3, 6'h00);
        expect_val("comb_in_reset_3p4p1", 2'd2, 6'h08);
        fire();

        // Release on a negedge; valid_q must stay low until the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        {a1, b1, cin1} = 3'b000;
        expect_val("valid_low_before_edge", 2'd1, 6'h00);
        expect_val("w1_comb_000", 2'd0, {4'b0, tbl1[0]});
        fire();

        // Exhaustive 1-bit truth table at 10 ns spacing, plus registered lag
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            expect_val($sformatf("w1_reg_after_%0d", i - 1), 2'd1, {3'b0, 1'b1, tbl1[i-1]});
            fire();
            {a1, b1, cin1} = 3'(i);
            expect_val($sformatf("w1_comb_%0d", i), 2'd0, {4'b0, tbl1[i]});
            fire();
        end

        // 1+1+0 registered: sum_q=0, cout_q=1, valid_q=1
        @(negedge clk);
        {a1, b1, cin1} = 3'b110;
        @(negedge clk);
        expect_val("w1_reg_1p1", 2'd1, 6'b000_110);
        fire();

        // 4-bit directed vectors including wrap-around
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        expect_val("w4_F_1_0", 2'd2, 6'h10);
        fire();
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        expect_val("w4_F_F_1", 2'd2, 6'h1F);
        fire();
        @(negedge clk);
        expect_val("w4_reg_F_F_1", 2'd3, 6'b11_1111);
        a4 = 4'h5; b4 = 4'hA; cin4 = 1'b0;
        expect_val("w4_5_A_0", 2'd2, 6'h0F);
        fire();
        a4 = 4'h7; b4 = 4'h8; cin4 = 1'b1;
        expect_val("w4_7_8_1", 2'd2, 6'h10);
        fire();
        @(negedge clk);
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        expect_val("w4_0_0_0", 2'd2, 6'h00);
        fire();

        // Asynchronous reset while sum_q holds 5
        a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0;
        @(negedge clk);
        expect_val("w4_reg_5", 2'd3, 6'b10_0101);
        fire();
        rst_n = 1'b0;
        expect_val("async_clear_w4", 2'd3, 6'h00);
        expect_val("async_clear_w1", 2'd1, 6'h00);
        fire();
        a4 = 4'h6; b4 = 4'h1; cin4 = 1'b1;
        expect_val("comb_tracks_in_reset", 2'd2, 6'h08);
        fire();
        @(negedge clk);
        expect_val("held_clear_over_edge", 2'd3, 6'h00);
        fire();
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("reload_after_release", 2'd3, 6'b10_1000);
        fire();

        // Two mid-cycle input changes: only the edge value is captured
        a4 = 4'h4; b4 = 4'h3; cin4 = 1'b0;
        expect_val("w4_4_3_0", 2'd2, 6'h07);
        fire();
        @(posedge clk);
        #1;
        a4 = 4'h1; b4 = 4'h1;
        #2;
        a4 = 4'h9; b4 = 4'h9;
        @(negedge clk);
        expect_val("midcycle_capture_7", 2'd3, 6'b10_0111);
        expect_val("w4_9_9_0", 2'd2, 6'h12);
        fire();
        @(negedge clk);
        expect_val("reg_9_9_0", 2'd3, 6'b11_0010);
        fire();

        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
